// File: rtl/tmds_pkg.sv
// Shared encodings, fixed symbols and the TERC4 lookup for the TMDS channel encoders.
package tmds_pkg;

    typedef enum logic [1:0] {
        MODE_CTRL  = 2'd0,
        MODE_VIDEO = 2'd1,
        MODE_TERC4 = 2'd2,
        MODE_GB    = 2'd3
    } tmds_mode_e;

    localparam logic [9:0] CTRLTOKEN0 = 10'b1101010100;
    localparam logic [9:0] CTRLTOKEN1 = 10'b0010101011;
    localparam logic [9:0] CTRLTOKEN2 = 10'b0101010100;
    localparam logic [9:0] CTRLTOKEN3 = 10'b1010101011;

    localparam logic [9:0] VGB_EVEN = 10'b1011001100;
    localparam logic [9:0] VGB_ODD  = 10'b0100110011;

    function automatic logic [9:0] terc4_enc(input logic [3:0] nibble);
        logic [9:0] sym;
        sym = 10'b0;
        case (nibble)
            4'h0: sym = 10'b1010011100;
            4'h1: sym = 10'b1001100011;
            4'h2: sym = 10'b1011100100;
            4'h3: sym = 10'b1011100010;
            4'h4: sym = 10'b0101110001;
            4'h5: sym = 10'b0100011110;
            4'h6: sym = 10'b0110001110;
            4'h7: sym = 10'b0100111100;
            4'h8: sym = 10'b1011001100;
            4'h9: sym = 10'b0100111001;
            4'hA: sym = 10'b0110011100;
            4'hB: sym = 10'b1011000111;
            4'hC: sym = 10'b1010001110;
            4'hD: sym = 10'b1001110001;
            4'hE: sym = 10'b0101100011;
            4'hF: sym = 10'b1011000011;
            default: sym = 10'b0;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/tmds_ch_enc.sv
// Single TMDS channel: 3-stage encoder for control, video, TERC4 and guard-band symbols.
module tmds_ch_enc
    import tmds_pkg::*;
#(
    parameter int unsigned CH_IDX = 0,
    parameter int unsigned DISP_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        mode_i,
    input  logic              gb_di_i,
    input  logic [7:0]        din_i,
    input  logic [1:0]        ctrl_i,
    input  logic [3:0]        terc4_i,
    output logic [9:0]        dout_o,
    output logic [DISP_W-1:0] disp_o
);

    // Video guard-band symbol alternates by channel parity; channel 0 carries TERC4 in DI guard.
    localparam logic [9:0] VgbSym = (CH_IDX % 2 == 0) ? VGB_EVEN : VGB_ODD;
    localparam bit         IsCh0  = (CH_IDX == 0);

    // Stage 1
    logic [7:0] din_s1_q;
    logic [3:0] n1_s1_q, n1_s1_d;
    tmds_mode_e mode_s1_q;
    logic       gb_di_s1_q;
    logic [1:0] ctrl_s1_q;
    logic [3:0] terc4_s1_q;

    // Stage 2
    logic [8:0] qm_s2_q, qm_s2_d;
    logic [3:0] n1qm_s2_q, n1qm_s2_d;
    logic [3:0] n0qm_s2_q, n0qm_s2_d;
    tmds_mode_e mode_s2_q;
    logic       gb_di_s2_q;
    logic [1:0] ctrl_s2_q;
    logic [3:0] terc4_s2_q;

    // Stage 3
    logic [9:0]               dout_q, dout_d;
    logic signed [DISP_W-1:0] cnt_q, cnt_d;

    logic                     decision;
    logic signed [DISP_W-1:0] n1_ext, n0_ext, two_q8, two_nq8;
    logic                     cnt_zero, cnt_pos, cnt_neg;

    // Stage 1 next state: ones count of the incoming video byte.
    always_comb begin
        n1_s1_d = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1_s1_d = n1_s1_d + {3'b000, din_i[i]};
        end
    end

    // Stage 2 next state: transition-minimised q_m and its ones/zeros counts.
    always_comb begin
        decision  = (n1_s1_q > 4'd4) || ((n1_s1_q == 4'd4) && !din_s1_q[0]);
        qm_s2_d    = 9'b0;
        qm_s2_d[0] = din_s1_q[0];
        for (int i = 1; i < 8; i++) begin
            qm_s2_d[i] = decision ? ~(qm_s2_d[i-1] ^ din_s1_q[i]) : (qm_s2_d[i-1] ^ din_s1_q[i]);
        end
        qm_s2_d[8] = ~decision;
        n1qm_s2_d  = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1qm_s2_d = n1qm_s2_d + {3'b000, qm_s2_d[i]};
        end
        n0qm_s2_d = 4'd8 - n1qm_s2_d;
    end

    // Stage 3 next state: output symbol and running disparity (cleared outside video).
    always_comb begin
        n1_ext   = {{(DISP_W-4){1'b0}}, n1qm_s2_q};
        n0_ext   = {{(DISP_W-4){1'b0}}, n0qm_s2_q};
        two_q8   = qm_s2_q[8] ? DISP_W'(2) : '0;
        two_nq8  = qm_s2_q[8] ? '0 : DISP_W'(2);
        cnt_zero = (cnt_q == '0);
        cnt_neg  = cnt_q[DISP_W-1];
        cnt_pos  = !cnt_neg && !cnt_zero;
        dout_d   = 10'b0;
        cnt_d    = '0;
        case (mode_s2_q)
            MODE_VIDEO: begin
                if (cnt_zero || (n1qm_s2_q == n0qm_s2_q)) begin
                    dout_d = {~qm_s2_q[8], qm_s2_q[8], qm_s2_q[8] ? qm_s2_q[7:0] : ~qm_s2_q[7:0]};
                    cnt_d  = qm_s2_q[8] ? (cnt_q + n1_ext - n0_ext) : (cnt_q + n0_ext - n1_ext);
                end else if ((cnt_pos && (n1qm_s2_q > n0qm_s2_q)) ||
                             (cnt_neg && (n0qm_s2_q > n1qm_s2_q))) begin
                    dout_d = {1'b1, qm_s2_q[8], ~qm_s2_q[7:0]};
                    cnt_d  = cnt_q + two_q8 + n0_ext - n1_ext;
                end else begin
                    dout_d = {1'b0, qm_s2_q[8], qm_s2_q[7:0]};
                    cnt_d  = cnt_q + n1_ext - n0_ext - two_nq8;
                end
            end
            MODE_CTRL: begin
                case (ctrl_s2_q)
                    2'b00:   dout_d = CTRLTOKEN0;
                    2'b01:   dout_d = CTRLTOKEN1;
                    2'b10:   dout_d = CTRLTOKEN2;
                    default: dout_d = CTRLTOKEN3;
                endcase
            end
            MODE_TERC4: dout_d = terc4_enc(terc4_s2_q);
            MODE_GB: begin
                if (gb_di_s2_q) begin
                    dout_d = IsCh0 ? terc4_enc(terc4_s2_q) : VGB_ODD;
                end else begin
                    dout_d = VgbSym;
                end
            end
            default: dout_d = 10'b0;
        endcase
    end

    // Pipeline registers for all three stages; reset flushes in-flight symbols.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            din_s1_q   <= 8'b0;
            n1_s1_q    <= 4'b0;
            mode_s1_q  <= MODE_CTRL;
            gb_di_s1_q <= 1'b0;
            ctrl_s1_q  <= 2'b0;
            terc4_s1_q <= 4'b0;
            qm_s2_q    <= 9'b0;
            n1qm_s2_q  <= 4'b0;
            n0qm_s2_q  <= 4'b0;
            mode_s2_q  <= MODE_CTRL;
            gb_di_s2_q <= 1'b0;
            ctrl_s2_q  <= 2'b0;
            terc4_s2_q <= 4'b0;
            dout_q     <= 10'b0;
            cnt_q      <= '0;
        end else begin
            din_s1_q   <= din_i;
            n1_s1_q    <= n1_s1_d;
            mode_s1_q  <= tmds_mode_e'(mode_i);
            gb_di_s1_q <= gb_di_i;
            ctrl_s1_q  <= ctrl_i;
            terc4_s1_q <= terc4_i;
            qm_s2_q    <= qm_s2_d;
            n1qm_s2_q  <= n1qm_s2_d;
            n0qm_s2_q  <= n0qm_s2_d;
            mode_s2_q  <= mode_s1_q;
            gb_di_s2_q <= gb_di_s1_q;
            ctrl_s2_q  <= ctrl_s1_q;
            terc4_s2_q <= terc4_s1_q;
            dout_q     <= dout_d;
            cnt_q      <= cnt_d;
        end
    end

    assign dout_o = dout_q;
    assign disp_o = cnt_q;

endmodule

// File: rtl/tmds_encoder_mc.sv
// Multi-channel TMDS/HDMI encoder: one independent channel encoder per lane, shared mode.
module tmds_encoder_mc
    import tmds_pkg::*;
#(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned DISP_W = 5
) (
    input  logic                     clkin,
    input  logic                     rstin,
    input  logic [1:0]               mode,
    input  logic                     gb_di,
    input  logic [8*NUM_CH-1:0]      din,
    input  logic [2*NUM_CH-1:0]      ctrl,
    input  logic [4*NUM_CH-1:0]      terc4,
    output logic [10*NUM_CH-1:0]     dout,
    output logic [DISP_W*NUM_CH-1:0] disp
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        tmds_ch_enc #(
            .CH_IDX (k),
            .DISP_W (DISP_W)
        ) u_ch_enc (
            .clk_i   (clkin),
            .rst_i   (rstin),
            .mode_i  (mode),
            .gb_di_i (gb_di),
            .din_i   (din[8*k +: 8]),
            .ctrl_i  (ctrl[2*k +: 2]),
            .terc4_i (terc4[4*k +: 4]),
            .dout_o  (dout[10*k +: 10]),
            .disp_o  (disp[DISP_W*k +: DISP_W])
        );
    end

endmodule

// File: tb/tb_tmds_encoder_mc.sv
// Directed and randomised checks of tmds_encoder_mc against a behavioural symbol model.
module tb_tmds_encoder_mc;

    localparam int NCH = 3;
    localparam int DW  = 5;

    localparam logic [9:0] TOK [4] = '{10'b1101010100, 10'b0010101011,
                                       10'b0101010100, 10'b1010101011};
    localparam logic [9:0] T4 [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000111,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    localparam logic [9:0] GB_E = 10'b1011001100;
    localparam logic [9:0] GB_O = 10'b0100110011;

    logic              clkin = 1'b0;
    logic              rstin = 1'b0;
    logic [1:0]        mode  = 2'd0;
    logic              gb_di = 1'b0;
    logic [8*NCH-1:0]  din   = '0;
    logic [2*NCH-1:0]  ctrl  = '0;
    logic [4*NCH-1:0]  terc4 = '0;
    logic [10*NCH-1:0] dout;
    logic [DW*NCH-1:0] disp;

    tmds_encoder_mc #(
        .NUM_CH (NCH),
        .DISP_W (DW)
    ) dut (
        .clkin (clkin),
        .rstin (rstin),
        .mode  (mode),
        .gb_di (gb_di),
        .din   (din),
        .ctrl  (ctrl),
        .terc4 (terc4),
        .dout  (dout),
        .disp  (disp)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        logic [1:0]       m;
        logic             g;
        logic [8*NCH-1:0] d;
        logic [2*NCH-1:0] c;
        logic [4*NCH-1:0] t;
    } sym_t;

    sym_t              pipe[$];
    int                cnt[NCH];
    logic [10*NCH-1:0] exp_dout;
    logic [DW*NCH-1:0] exp_disp;
    int                n_checks = 0;
    int                n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Encode one symbol for channel k, advancing the model disparity.
    task automatic enc(input sym_t s, input int k, output logic [9:0] sym);
        logic [7:0] d, qm;
        int         n1d, n1, n0, q8;
        bit         dec;
        sym = 10'b0;
        case (s.m)
            2'd0: begin sym = TOK[s.c[2*k +: 2]]; cnt[k] = 0; end
            2'd2: begin sym = T4[s.t[4*k +: 4]];  cnt[k] = 0; end
            2'd3: begin
                if (s.g) sym = (k == 0) ? T4[s.t[3:0]] : GB_O;
                else     sym = (k % 2 == 0) ? GB_E : GB_O;
                cnt[k] = 0;
            end
            default: begin
                d   = s.d[8*k +: 8];
                n1d = $countones(d);
                dec = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
                qm[0] = d[0];
                for (int i = 1; i < 8; i++) qm[i] = dec ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
                q8 = dec ? 0 : 1;
                n1 = $countones(qm);
                n0 = 8 - n1;
                if (cnt[k] == 0 || n1 == n0) begin
                    sym = {~q8[0], q8[0], (q8 == 1) ? qm : ~qm};
                    cnt[k] += (q8 == 1) ? (n1 - n0) : (n0 - n1);
                end else if ((cnt[k] > 0 && n1 > n0) || (cnt[k] < 0 && n0 > n1)) begin
                    sym = {1'b1, q8[0], ~qm};
                    cnt[k] += 2 * q8 + n0 - n1;
                end else begin
                    sym = {1'b0, q8[0], qm};
                    cnt[k] += n1 - n0 - 2 * (1 - q8);
                end
            end
        endcase
    endtask

    // Drive one cycle, advance the model on the edge, then compare just after it.
    task automatic step(input logic r, input logic [1:0] m, input logic g,
                        input logic [8*NCH-1:0] d, input logic [2*NCH-1:0] c,
                        input logic [4*NCH-1:0] t);
        sym_t       cur, old, zero;
        logic [9:0] sym;
        int         cv;
        logic signed [DW-1:0] dv;
        rstin = r; mode = m; gb_di = g; din = d; ctrl = c; terc4 = t;
        cur = '{m: m, g: g, d: d, c: c, t: t};
        zero = '{m: 2'd0, g: 1'b0, d: '0, c: '0, t: '0};
        @(posedge clkin);
        if (r) begin
            pipe.delete();
            pipe.push_back(zero);
            pipe.push_back(zero);
            for (int k = 0; k < NCH; k++) cnt[k] = 0;
            exp_dout = '0;
            exp_disp = '0;
        end else begin
            pipe.push_back(cur);
            old = pipe.pop_front();
            for (int k = 0; k < NCH; k++) begin
                enc(old, k, sym);
                exp_dout[10*k +: 10] = sym;
                cv = cnt[k];
                exp_disp[DW*k +: DW] = cv[DW-1:0];
            end
        end
        #1;
        chk("dout_model", 64'(dout), 64'(exp_dout));
        chk("disp_model", 64'(disp), 64'(exp_disp));
        for (int k = 0; k < NCH; k++) begin
            dv = disp[DW*k +: DW];
            chk("disp_bound", 64'(dv >= -10 && dv <= 10), 64'd1);
        end
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        logic [31:0] r0, r1;
        logic        rr;

        // Reset held with video input: outputs stay zero.
        step(1'b1, 2'd1, 1'b0, {NCH{8'hFF}}, '0, '0);
        chk("reset_dout0", 64'(dout), 64'd0);
        chk("reset_disp0", 64'(disp), 64'd0);
        step(1'b1, 2'd1, 1'b0, {NCH{8'hFF}}, '0, '0);
        chk("reset_dout1", 64'(dout), 64'd0);
        chk("reset_disp1", 64'(disp), 64'd0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("post_reset_tok0", 64'(dout), 64'({NCH{10'b1101010100}}));
        end

        // Video 0x00 twice from cnt=0.
        step(1'b0, 2'd1, 1'b0, '0, '0, '0);
        step(1'b0, 2'd1, 1'b0, '0, '0, '0);
        idle();
        chk("video_sym1", 64'(dout[9:0]), 64'(10'b0100000000));
        chk("video_disp1", 64'(disp[DW-1:0]), 64'(5'b11000));
        idle();
        chk("video_sym2", 64'(dout[9:0]), 64'(10'b1111111111));
        chk("video_disp2", 64'(disp[DW-1:0]), 64'(5'b00010));

        // Control tokens, then a video symbol that must restart from cnt=0.
        step(1'b0, 2'd0, 1'b0, '0, {2'b11, 2'b01, 2'b00}, '0);
        step(1'b0, 2'd1, 1'b0, '0, '0, '0);
        idle();
        chk("ctrl_tokens", 64'(dout), 64'({10'b1010101011, 10'b0010101011, 10'b1101010100}));
        chk("ctrl_disp", 64'(disp), 64'd0);
        idle();
        chk("video_after_ctrl", 64'(dout[9:0]), 64'(10'b0100000000));
        chk("video_after_ctrl_disp", 64'(disp[DW-1:0]), 64'(5'b11000));

        // TERC4 data island.
        step(1'b0, 2'd2, 1'b0, '0, '0, {4'hF, 4'h8, 4'h0});
        idle();
        idle();
        chk("terc4", 64'(dout), 64'({10'b1011000011, 10'b1011001100, 10'b1010011100}));

        // Guard bands, video then data island.
        step(1'b0, 2'd3, 1'b0, '0, '0, '0);
        step(1'b0, 2'd3, 1'b1, '0, '0, {4'h0, 4'h0, 4'hC});
        idle();
        chk("gb_video", 64'(dout), 64'({10'b1011001100, 10'b0100110011, 10'b1011001100}));
        idle();
        chk("gb_island", 64'(dout), 64'({10'b0100110011, 10'b0100110011, 10'b1010001110}));

        // Randomised stream with occasional mid-stream resets; video favoured for disparity.
        for (int n = 0; n < 10000; n++) begin
            r0 = $urandom;
            r1 = $urandom;
            rr = ($urandom_range(0, 199) == 0);
            step(rr, ($urandom_range(0, 3) == 0) ? r0[25:24] : 2'd1, r0[26],
                 r1[23:0], r0[5:0], r0[17:6]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tmds_encoder_mc.md
Name: tmds_encoder_mc

Overview:
Parametrised multi-channel TMDS/HDMI channel encoder that succeeds the single-channel DVI encoder. It adds HDMI data-island TERC4 coding, video and data-island guard bands, and a per-channel running-disparity status output. It sits between the HDMI timing/packet generator and the 10:1 serialisers, with one 10-bit symbol per channel per pixel clock.

Parameters:
NUM_CH, 3, number of TMDS channels; channel 0 = blue/sync, 1 = green, 2 = red; range 1..4.
DISP_W, 5, width of the signed disparity counter; MSB is the sign bit; minimum 5.

Ports:
clkin  in  1  pixel clock
rstin  in  1  reset, synchronous, active-high
mode  in  2  shared symbol mode: 0 = control, 1 = video, 2 = TERC4 data island, 3 = guard band
gb_di  in  1  guard band kind when mode=3: 0 = video guard band, 1 = data-island guard band
din  in  8*NUM_CH  video byte per channel; channel k at [8k+7:8k]
ctrl  in  2*NUM_CH  {c1,c0} per channel; channel k at [2k+1:2k]
terc4  in  4*NUM_CH  TERC4 nibble per channel; channel k at [4k+3:4k]
dout  out  10*NUM_CH  registered symbol per channel; channel k at [10k+9:10k]
disp  out  DISP_W*NUM_CH  current disparity counter per channel, two's complement

Behaviour:
- Reset is synchronous: on a clkin edge with rstin=1, dout=0, disp=0, all pipeline registers=0. A pipeline register value of 0 means mode 0 with ctrl 00.
- Latency is fixed at 3 cycles for every mode. Inputs sampled at edge N appear on dout after edge N+2 (third register stage).
  - Stage 1 registers din, the ones count of din, mode, gb_di, ctrl and terc4.
  - Stage 2 registers q_m[8:0], n1q_m and n0q_m, plus the aligned mode/ctrl/terc4.
  - Stage 3 registers dout and the disparity counter.
- After rstin deasserts, the first 3 symbols are CTRLTOKEN0 (1101010100) on every channel.
- Video mode, stage 1 (per DVI 1.0 transition minimisation):
  - decision1 = (n1 > 4) or (n1 == 4 and din[0] == 0).
  - q_m[0] = din[0].
  - q_m[i] = q_m[i-1] XNOR din[i] if decision1, else XOR.
  - q_m[8] = not decision1.
- Video mode, stage 3 (DC balance):
  - If cnt == 0 or n1q_m == n0q_m: dout = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}; cnt += q_m[8] ? (n1 - n0) : (n0 - n1).
  - Else if (cnt > 0 and n1 > n0) or (cnt < 0 and n0 > n1): dout = {1, q_m[8], ~q_m[7:0]}; cnt += 2*q_m[8] + n0 - n1.
  - Else: dout = {0, q_m[8], q_m[7:0]}; cnt += n1 - n0 - 2*(~q_m[8]).
  - All arithmetic is sign-extended to DISP_W; wrap-around cannot occur because |cnt| <= 10.
- Control mode, by {c1,c0}:
  - 00 -> 1101010100
  - 01 -> 0010101011
  - 10 -> 0101010100
  - 11 -> 1010101011
- TERC4 mode uses the HDMI TERC4 table, indices 0..15:
  - 0..3: 1010011100, 1001100011, 1011100100, 1011100010
  - 4..7: 0101110001, 0100011110, 0110001110, 0100111100
  - 8..11: 1011001100, 0100111001, 0110011100, 1011000111
  - 12..15: 1010001110, 1001110001, 0101100011, 1011000011
- Guard band mode, gb_di=0 (video guard band): even channels emit 1011001100, odd channels emit 0100110011.
- Guard band mode, gb_di=1 (data-island guard band): channel 0 emits TERC4(terc4[3:0]); channels >= 1 emit 0100110011.
- In every non-video mode, cnt is cleared to 0 at stage 3. The disparity counter therefore always restarts from 0 at the first video symbol after blanking.
- Mode may change on any cycle. Each symbol is encoded with the mode that accompanied it, so there is no bleed between adjacent symbols.
- If rstin asserts mid-stream, it wins over all other activity on that edge. In-flight symbols are discarded and never emitted.
- Channels are fully independent except for the shared mode and gb_di.

Decomposition:
- Package tmds_pkg holds:
  - mode encodings MODE_CTRL, MODE_VIDEO, MODE_TERC4, MODE_GB
  - CTRLTOKEN0..3
  - VGB_EVEN and VGB_ODD
  - the TERC4 lookup function terc4_enc(nibble) returning 10 bits
- Sub-module tmds_ch_enc is a single-channel 3-stage encoder with a CH_IDX parameter and a DISP_W parameter. The top level instantiates it NUM_CH times through a generate loop and only slices the flat buses.

Test Plan:
- Reset: hold rstin for 2 cycles with mode=1 and din=0xFF -> dout=0 and disp=0 throughout. After release, 3 cycles of 1101010100 on all channels.
- Video DC balance, ch0, mode=1, din=0x00 twice from cnt=0:
  - symbol 1 = 0100000000 with disp=-8
  - symbol 2 = 1111111111 with disp=+2
  - both appear exactly 3 cycles after their inputs.
- Control: mode=0, ctrl ch0..2 = 00/01/11 -> 1101010100 / 0010101011 / 1010101011 at T+3. The following video symbol starts from cnt=0.
- TERC4: mode=2, terc4 ch0..2 = 0x0/0x8/0xF -> 1010011100 / 1011001100 / 1011000011.
- Guard bands:
  - mode=3, gb_di=0 -> ch0/ch1/ch2 = 1011001100 / 0100110011 / 1011001100.
  - gb_di=1 with terc4 ch0=0xC -> 1010001110 / 0100110011 / 0100110011.
- Mixed stream: random mode and data each cycle for 10k cycles, compared against a reference model, plus rstin pulses mid-stream. Required: bit-exact dout, |disp| <= 10, and no in-flight symbols emitted after reset.
